seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//   Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   Sits directly upstream of the two-digit seven-segment display driver.
//   quotient feeds num_1; remainder feeds num_2.
//   Operands come from board switches; start comes from a debounced button pulse.
// PARAMETERS
//   WIDTH   4   operand/result width in bits (>=2); drives CALC length
// PORTS
//   clk          in   1      system clock; all state changes on rising edge
//   reset        in   1      asynchronous, active-high; clears all state immediately
//   start        in   1      request a division; sampled only when busy=0
//   dividend     in   WIDTH  unsigned dividend; captured when start is accepted
//   divisor      in   WIDTH  unsigned divisor; captured when start is accepted
//   quotient     out  WIDTH  registered quotient; held until the next completion
//   remainder    out  WIDTH  registered remainder; held until the next completion
//   busy         out  1      1 while in CALC
//   done         out  1      one-cycle pulse: results just updated
//   div_by_zero  out  1      flag for the last completed op; held until the next completion
// BEHAVIOUR
//   Reset:
//     - clk and reset are the only clock and reset; reset is asynchronous and active-high.
//     - On reset: state=IDLE; quotient, remainder, busy, done, div_by_zero = 0; internal regs = 0.
//     - Takes effect without a clock edge, including in the middle of CALC.
//     - An in-flight operation is discarded; no done pulse is produced for it.
//   FSM states: IDLE, CALC, FINISH. busy = (state==CALC); done = (state==FINISH).
//   Start acceptance: start=1 at an edge while state is IDLE or FINISH. busy=0 in both.
//     - divisor!=0: latch divisor. q_sh <= dividend, acc <= 0, cnt <= WIDTH. Go to CALC.
//     - divisor==0: skip CALC and go to FINISH. At that same edge:
//       quotient <= all ones, remainder <= dividend, div_by_zero <= 1.
//   start while busy=1 is ignored. Operand changes during CALC are ignored.
//   CALC step, one per edge:
//     - acc is WIDTH+1 bits.
//     - sh = {acc[WIDTH-1:0], q_sh[WIDTH-1]}; trial = sh - {1'b0, divisor_r}.
//     - trial[WIDTH]==0: acc <= trial, q_sh <= {q_sh[WIDTH-2:0], 1}.
//     - otherwise: acc <= sh, q_sh <= {q_sh[WIDTH-2:0], 0}.
//     - cnt <= cnt-1.
//   Last step (cnt==1):
//     - quotient <= new q_sh; remainder <= new acc[WIDTH-1:0]; div_by_zero <= 0.
//     - Go to FINISH.
//   Latency:
//     - Start accepted at edge E0; last step at E(WIDTH); done=1 in the cycle after E(WIDTH).
//     - WIDTH=4: done after the 4th edge following acceptance.
//     - divisor==0: done=1 in the cycle right after E0.
//   FINISH lasts one cycle. Next state is IDLE, or CALC/FINISH if start is accepted there.
//     - Back-to-back operations therefore pay no extra idle cycle.
//   Invariants:
//     - quotient*divisor + remainder == dividend; remainder < divisor (divisor!=0).
//     - Outputs change only at completion edges or on reset, so the display never shows partial results.
//     - cnt is ceil(log2(WIDTH+1)) bits and never wraps: CALC always exits at cnt==1.
// TESTING
//   1. dividend=13, divisor=3, start pulse -> busy for 4 cycles, then done=1 for 1 cycle; quotient=4, remainder=1, div_by_zero=0.
//   2. 15/1 -> quotient=15, remainder=0. 2/7 -> quotient=0, remainder=2. 0/5 -> quotient=0, remainder=0.
//   3. 9/0 -> done 1 cycle after start, busy never set; quotient=15, remainder=9, div_by_zero=1. Then 8/2 -> 4 r0, div_by_zero=0.
//   4. 13/3 in progress; change operands to 6/2 and pulse start at cycle 2 -> ignored; result is still 4 r1.
//   5. Start asserted during the FINISH cycle of 13/3 with 14/4 -> done after 4 more edges with quotient=3, remainder=2, no idle gap.
//   6. Assert reset mid-clock during CALC of 12/5 -> all outputs 0 at once, no done pulse. Release, then 12/5 -> 2 r2.
//   Also: exhaustive self-check of all 256 operand pairs (WIDTH=4) against / and % in the bench.

Source files
------------

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider producing one quotient bit per clock.
// Results are registered and change only at completion, so a display driven from them never shows partial values.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [1:0]       state_dbg
);

  // Handshake: start is accepted at a rising edge whenever busy=0 (IDLE or FINISH);
  // operands are captured at that edge. done pulses high for exactly one cycle when
  // quotient/remainder/div_by_zero have just been updated.

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH:0]   acc;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   step_acc;
  logic [WIDTH-1:0] step_q;
  logic             last_step;

  assign busy      = (state == CALC);
  assign done      = (state == FINISH);
  assign state_dbg = state;
  assign last_step = (cnt == CW'(1));

  // One restoring step: shift in the next dividend bit, keep the trial subtraction if it did not borrow.
  always_comb begin
    sh    = {acc[WIDTH-1:0], q_sh[WIDTH-1]};
    trial = sh - {1'b0, divisor_r};
    if (trial[WIDTH] == 1'b0) begin
      step_acc = trial;
      step_q   = {q_sh[WIDTH-2:0], 1'b1};
    end else begin
      step_acc = sh;
      step_q   = {q_sh[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, FINISH: begin
        if (start) begin
          state_next = (divisor == '0) ? FINISH : CALC;
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
        if (last_step) begin
          state_next = FINISH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      divisor_r   <= '0;
      q_sh        <= '0;
      acc         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE, FINISH: begin
          if (start) begin
            if (divisor == '0) begin
              // Division by zero completes immediately with a saturated quotient.
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              divisor_r <= divisor;
              q_sh      <= dividend;
              acc       <= '0;
              cnt       <= CW'(WIDTH);
            end
          end
        end
        CALC: begin
          acc  <= step_acc;
          q_sh <= step_q;
          cnt  <= cnt - CW'(1);
          if (last_step) begin
            quotient    <= step_q;
            remainder   <= step_acc[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomised and directed bench for seq_divider: driver tasks issue divisions, a scoreboard
// queue holds arithmetic expectations, and a monitor compares them on every done pulse.
module tb_seq_divider;

  localparam int W = 4;
  localparam int EW = 2 * W + 1;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [1:0]   state_dbg;

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] held;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: plain arithmetic on the operands
  function automatic logic [EW-1:0] model(input int a, input int b);
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (b == 0) begin
      q = '1;
      r = W'(a);
      return {q, r, 1'b1};
    end
    q = W'(a / b);
    r = W'(a % b);
    return {q, r, 1'b0};
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("quotient", 32'(quotient), 32'(e[EW-1 -: W]));
          check("remainder", 32'(remainder), 32'(e[W:1]));
          check("div_by_zero", 32'(div_by_zero), 32'(e[0]));
        end
      end else if ({quotient, remainder, div_by_zero} !== held) begin
        check("outputs_held", 32'({quotient, remainder, div_by_zero}), 32'(held));
      end
    end
    held = {quotient, remainder, div_by_zero};
  end

  // driver: present operands with start for one edge; returns at edge+1
  task automatic issue(input int a, input int b, input bit push);
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) exp_q.push_back(model(a, b));
  endtask

  // counts rising edges until done is seen; ends at the negedge where done=1
  task automatic wait_done(input int exp_n, input bit exp_busy, input string tag);
    int n = 0;
    @(negedge clk);
    check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    while (!done && n < 3 * W + 4) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(exp_n));
  endtask

  task automatic run_op(input int a, input int b, input string tag);
    issue(a, b, 1'b1);
    wait_done((b == 0) ? 0 : W, (b != 0), tag);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #1;
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    idle_cycles(2);
    reset = 1'b0;
    idle_cycles(1);

    // directed operations
    run_op(13, 3, "d13_3");
    idle_cycles(1);
    run_op(15, 1, "d15_1");
    idle_cycles(1);
    run_op(2, 7, "d2_7");
    run_op(0, 5, "d0_5");
    idle_cycles(2);
    run_op(9, 0, "d9_0");
    idle_cycles(1);
    run_op(8, 2, "d8_2");
    idle_cycles(1);

    // start and operand changes during CALC must be ignored
    issue(13, 3, 1'b1);
    @(posedge clk);
    #1;
    dividend = 4'd6;
    divisor  = 4'd2;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(W - 2, 1'b1, "busy_ignore");

    // back-to-back: start accepted in the FINISH cycle of the previous op
    idle_cycles(1);
    run_op(13, 3, "b2b_first");
    run_op(14, 4, "b2b_second");
    run_op(7, 0, "b2b_zero");
    run_op(11, 2, "b2b_after_zero");

    // asynchronous reset in the middle of CALC discards the operation
    idle_cycles(1);
    issue(12, 5, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("midrst_quotient", 32'(quotient), 32'd0);
    check("midrst_remainder", 32'(remainder), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_dbz", 32'(div_by_zero), 32'd0);
    check("midrst_state", 32'(state_dbg), 32'd0);
    idle_cycles(2);
    reset = 1'b0;
    idle_cycles(W + 2);
    check("midrst_no_done", 32'(done), 32'd0);
    run_op(12, 5, "after_rst");

    // exhaustive operand sweep with random idle gaps
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        run_op(a, b, "sweep");
        idle_cycles($urandom_range(0, 1));
      end
    end

    // random operands with input noise while busy
    for (int k = 0; k < 60; k++) begin
      int a;
      int b;
      a = $urandom_range(0, (1 << W) - 1);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, (1 << W) - 1);
      issue(a, b, 1'b1);
      dividend = W'($urandom_range(0, (1 << W) - 1));
      divisor  = W'($urandom_range(0, (1 << W) - 1));
      wait_done((b == 0) ? 0 : W, (b != 0), "rand");
      idle_cycles($urandom_range(0, 2));
    end

    idle_cycles(3);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
